// File: rtl/mips_boot_loader_pkg.sv
// Shared definitions for the MIPS boot loader: FSM state encoding and frame layout constants.
package mips_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR_ADDR = 3'd0,
        ST_HDR_CNT  = 3'd1,
        ST_DATA     = 3'd2,
        ST_CSUM     = 3'd3,
        ST_DONE     = 3'd4,
        ST_ERR      = 3'd5
    } ldr_state_e;

    localparam int BYTES_PER_WORD = 4;

    // States in which the loader is still consuming frame bytes.
    function automatic logic is_rx_state(input ldr_state_e st);
        return (st != ST_DONE) && (st != ST_ERR);
    endfunction

endpackage

// File: rtl/mips_boot_loader_ldr_word_asm.sv
// Big-endian byte-to-word assembler: the fourth accepted byte completes a word,
// flagged by a combinational word_valid pulse in the accepting cycle.
module ldr_word_asm
    import mips_boot_loader_pkg::*;
(
    input  logic        clk1,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  idx_q, idx_d;
    logic [23:0] shift_q, shift_d;

    // Next byte index / shift contents and the word completed by the current byte.
    always_comb begin
        idx_d      = idx_q;
        shift_d    = shift_q;
        word       = {shift_q, byte_data};
        word_valid = 1'b0;
        if (clr) begin
            idx_d   = 2'd0;
            shift_d = 24'd0;
        end else if (byte_valid) begin
            shift_d    = {shift_q[15:0], byte_data};
            idx_d      = idx_q + 2'd1;
            word_valid = (idx_q == 2'(BYTES_PER_WORD - 1));
        end else begin
            idx_d   = idx_q;
            shift_d = shift_q;
        end
    end

    // Byte index and shift register state.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            idx_q   <= 2'd0;
            shift_q <= 24'd0;
        end else begin
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/mips_boot_loader.sv
// Boot loader for pipe_MIPS32: writes a framed byte-stream image into memory and releases the core.
// Build option: define MIPS_LOADER_CSUM_EN to require a trailing 32-bit wrapping checksum word.
module mips_boot_loader
    import mips_boot_loader_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int MAX_WORDS   = 1024,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    input  logic              load_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic [31:0]       core_pc,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;
    localparam int WL_W = ADDR_W + 1;

`ifdef MIPS_LOADER_CSUM_EN
    localparam ldr_state_e POST_PAYLOAD = ST_CSUM;
`else
    localparam ldr_state_e POST_PAYLOAD = ST_DONE;
`endif

    ldr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] start_q, start_d;
    logic [WL_W-1:0]   cnt_q, cnt_d;
    logic [WL_W-1:0]   words_loaded_q, words_loaded_d;
    logic [31:0]       csum_q, csum_d;
    logic [31:0]       core_pc_q, core_pc_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic              s_ready_q, s_ready_d;
    logic              core_hold_q, core_hold_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              to_run_q, to_run_d;

    logic              byte_xfer_s;
    logic              asm_clr_s;
    logic              word_valid_s;
    logic [31:0]       word_s;
    logic [32:0]       frame_end_s;
    logic [WL_W-1:0]   wl_next_s;

    assign byte_xfer_s = s_valid & s_ready_q;
    assign asm_clr_s   = load_req & ~is_rx_state(state_q);
    assign frame_end_s = {1'b0, word_s} + 33'(start_q);
    assign wl_next_s   = words_loaded_q + WL_W'(1);

    ldr_word_asm u_word_asm (
        .clk1       (clk1),
        .rst        (rst),
        .clr        (asm_clr_s),
        .byte_valid (byte_xfer_s),
        .byte_data  (s_data),
        .word       (word_s),
        .word_valid (word_valid_s)
    );

    // Frame FSM, write strobe generation, checksum and inter-byte timeout.
    always_comb begin
        state_d        = state_q;
        start_d        = start_q;
        cnt_d          = cnt_q;
        words_loaded_d = words_loaded_q;
        csum_d         = csum_q;
        core_pc_d      = core_pc_q;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        to_cnt_d       = to_cnt_q;
        to_run_d       = to_run_q;

        case (state_q)
            ST_HDR_ADDR: begin
                if (!word_valid_s) begin
                    state_d = state_q;
                end else if (word_s[31:ADDR_W] != '0) begin
                    state_d = ST_ERR;
                end else begin
                    start_d   = word_s[ADDR_W-1:0];
                    core_pc_d = word_s;
                    state_d   = ST_HDR_CNT;
                end
            end
            ST_HDR_CNT: begin
                if (!word_valid_s) begin
                    state_d = state_q;
                end else if ((word_s > 32'(MAX_WORDS)) || (frame_end_s > 33'(2 ** ADDR_W))) begin
                    state_d = ST_ERR;
                end else if (word_s == 32'd0) begin
                    state_d = POST_PAYLOAD;
                end else begin
                    cnt_d   = word_s[WL_W-1:0];
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (word_valid_s) begin
                    mem_we_d       = 1'b1;
                    mem_addr_d     = start_q + words_loaded_q[ADDR_W-1:0];
                    mem_wdata_d    = word_s;
                    words_loaded_d = wl_next_s;
                    csum_d         = csum_q + word_s;
                    state_d        = (wl_next_s == cnt_q) ? POST_PAYLOAD : ST_DATA;
                end else begin
                    state_d = state_q;
                end
            end
            ST_CSUM: begin
                if (word_valid_s) begin
                    state_d = (word_s == csum_q) ? ST_DONE : ST_ERR;
                end else begin
                    state_d = state_q;
                end
            end
            ST_DONE, ST_ERR: begin
                if (load_req) begin
                    state_d        = ST_HDR_ADDR;
                    words_loaded_d = '0;
                    csum_d         = 32'd0;
                    to_cnt_d       = '0;
                    to_run_d       = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = ST_ERR;
        endcase

        // The timer only arms once the first byte of a frame has been taken.
        if (!is_rx_state(state_q)) begin
            to_run_d = to_run_d;
        end else if (byte_xfer_s) begin
            to_cnt_d = '0;
            to_run_d = 1'b1;
        end else if (to_run_q) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
            state_d  = (to_cnt_d == TO_W'(TIMEOUT_CYC - 1)) ? ST_ERR : state_d;
        end else begin
            to_cnt_d = to_cnt_q;
        end

        s_ready_d   = is_rx_state(state_d);
        core_hold_d = (state_d != ST_DONE);
        done_d      = (state_d == ST_DONE);
        error_d     = (state_d == ST_ERR);
    end

    // State and registered outputs.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q        <= ST_HDR_ADDR;
            start_q        <= '0;
            cnt_q          <= '0;
            words_loaded_q <= '0;
            csum_q         <= 32'd0;
            core_pc_q      <= 32'd0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= 32'd0;
            s_ready_q      <= 1'b1;
            core_hold_q    <= 1'b1;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            to_cnt_q       <= '0;
            to_run_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            start_q        <= start_d;
            cnt_q          <= cnt_d;
            words_loaded_q <= words_loaded_d;
            csum_q         <= csum_d;
            core_pc_q      <= core_pc_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            s_ready_q      <= s_ready_d;
            core_hold_q    <= core_hold_d;
            done_q         <= done_d;
            error_q        <= error_d;
            to_cnt_q       <= to_cnt_d;
            to_run_q       <= to_run_d;
        end
    end

    assign s_ready      = s_ready_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign core_hold    = core_hold_q;
    assign core_pc      = core_pc_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_loaded_q;

endmodule
